// File: rtl/hilo_divider.sv
// hilo_divider
//   HI/LO result register unit sitting after the ALU in the execute stage.
//   Holds the HI and LO registers, captures multu results, accepts mthi/mtlo
//   writes and runs an iterative restoring divider (div / divu) that writes
//   the quotient to LO and the remainder to HI.
//
// Ports
//   clock        in   1      rising-edge clock
//   reset        in   1      asynchronous, active-low
//   alu_r        in   WIDTH  multu low word
//   alu_r2       in   WIDTH  multu high word
//   wr_hilo      in   1      {hi, lo} <= {alu_r2, alu_r}
//   mthi         in   1      hi <= mt_data
//   mtlo         in   1      lo <= mt_data
//   mt_data      in   WIDTH  data for mthi / mtlo
//   div_start    in   1      start a divide, operands sampled on this edge
//   div_signed   in   1      1 = div (two's complement), 0 = divu
//   div_a        in   WIDTH  dividend
//   div_b        in   WIDTH  divisor
//   hi           out  WIDTH  HI register
//   lo           out  WIDTH  LO register
//   busy         out  1      divide in flight (state != IDLE)
//   div_done     out  1      one-cycle pulse, hi/lo hold the new result
//   div_by_zero  out  1      qualified by div_done, divisor was zero
//   state_dbg    out  2      current FSM state for observation
//
// Handshake: div_start is a single-cycle request that is accepted only when
//   busy is low (the FSM is in IDLE). Every accepted request produces exactly
//   one div_done pulse unless reset aborts it. Requests and register writes
//   presented while busy is high are dropped; the pipeline must stall on busy.
//
// Timing (N = WIDTH / BITS_PER_CYCLE): start at edge 0, PREP at edge 1,
//   N iteration edges, FIX writes HI/LO at edge N+2 with div_done high after
//   it. A zero divisor skips ITER, so the result appears after edge 2.

module hilo_divider #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1    // 1, 2 or 4; must divide WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] alu_r,
    input  logic [WIDTH-1:0] alu_r2,
    input  logic             wr_hilo,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] mt_data,
    input  logic             div_start,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] div_a,
    input  logic [WIDTH-1:0] div_b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             div_done,
    output logic             div_by_zero,
    output logic [1:0]       state_dbg
);

    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        ITER = 2'd2,
        FIX  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    // Divide datapath. quo starts as |dividend| and shifts left one bit per
    // restoring step while quotient bits enter at the bottom, so after N
    // iterations it holds the unsigned quotient.
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] a_raw;     // original dividend, returned in HI on /0
    logic [CNT_W-1:0] count;
    logic             q_neg;
    logic             r_neg;
    logic             dz;

    // Operand magnitudes for the signed case. -x of the most negative value
    // is itself, which read as unsigned is exactly its magnitude.
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic             a_neg;
    logic             b_neg;

    always_comb begin
        a_neg = div_signed & div_a[WIDTH-1];
        b_neg = div_signed & div_b[WIDTH-1];
        a_abs = a_neg ? -div_a : div_a;
        b_abs = b_neg ? -div_b : div_b;
    end

    // One iteration's worth of restoring steps. rem is always below the
    // divisor, so the shifted trial value needs one extra bit.
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;
    logic [WIDTH:0]   trial;

    always_comb begin
        step_rem = rem;
        step_quo = quo;
        trial    = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            trial    = {step_rem, step_quo[WIDTH-1]};
            step_quo = {step_quo[WIDTH-2:0], 1'b0};
            if (trial >= {1'b0, divisor}) begin
                trial       = trial - {1'b0, divisor};
                step_quo[0] = 1'b1;
            end
            step_rem = trial[WIDTH-1:0];
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (div_start) begin
                    state_next = PREP;
                end
            end
            PREP: begin
                state_next = (divisor == '0) ? FIX : ITER;
            end
            ITER: begin
                if (count == CNT_W'(1)) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register and datapath
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            hi          <= '0;
            lo          <= '0;
            quo         <= '0;
            rem         <= '0;
            divisor     <= '0;
            a_raw       <= '0;
            count       <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            dz          <= 1'b0;
            div_done    <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            state       <= state_next;
            div_done    <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                IDLE: begin
                    // div_start wins; a same-edge wr_hilo/mthi/mtlo is dropped.
                    if (div_start) begin
                        a_raw   <= div_a;
                        quo     <= a_abs;
                        divisor <= b_abs;
                        q_neg   <= a_neg ^ b_neg;
                        r_neg   <= a_neg;
                    end else if (wr_hilo) begin
                        hi <= alu_r2;
                        lo <= alu_r;
                    end else begin
                        if (mthi) hi <= mt_data;
                        if (mtlo) lo <= mt_data;
                    end
                end
                PREP: begin
                    rem   <= '0;
                    count <= CNT_W'(N);
                    dz    <= (divisor == '0);
                end
                ITER: begin
                    rem   <= step_rem;
                    quo   <= step_quo;
                    count <= count - CNT_W'(1);
                end
                FIX: begin
                    if (dz) begin
                        lo <= '1;
                        hi <= a_raw;
                    end else begin
                        // Quotient truncates toward zero; remainder follows
                        // the dividend's sign.
                        lo <= q_neg ? -quo : quo;
                        hi <= r_neg ? -rem : rem;
                    end
                    div_done    <= 1'b1;
                    div_by_zero <= dz;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule
